ifu_fetch_ctrl: RTL
===================

Name: ifu_fetch_ctrl

Overview:
- Upstream instruction-fetch controller between the PC/IFU front end and the instruction memory port.
- Latches the current PC and issues a req/gnt request to memory, then waits for a variable-latency response.
- Presents the fetched instruction to the IFU with a valid/consume handshake.
- Handles redirects (branch/jump) that arrive mid-fetch, misaligned PCs, and memory timeouts.

Parameters:
- ADDR_W, 64, instruction address width (matches InstAddrBus).
- INST_W, 32, instruction width (matches InstBus).
- TIMEOUT, 255, maximum WAIT cycles before a fetch is declared failed; 8-bit counter.
- NOP_INST, 32'h00000013, instruction substituted on any fetch error.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pc_i  in  ADDR_W  PC to fetch
- ce_i  in  1  PC valid / fetch enable
- redirect_i  in  1  PC redirect (pcsel); pc_i carries the new target
- consume_i  in  1  downstream accepts the held instruction
- inst_o  out  INST_W  fetched instruction
- inst_pc_o  out  ADDR_W  PC of inst_o
- inst_valid_o  out  1  inst_o/inst_pc_o valid
- err_o  out  1  held instruction is an error substitute
- busy_o  out  1  fetch in flight; PC must hold
- mem_req_o  out  1  memory request
- mem_addr_o  out  ADDR_W  request address
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  response valid
- mem_rdata_i  in  INST_W  response data
- mem_err_i  in  1  response error, sampled with rvalid

Behaviour:
- Reset (async, immediate) values:
  - State = IDLE.
  - Outputs: inst_o=0, inst_pc_o=0, inst_valid_o=0, err_o=0, busy_o=0, mem_req_o=0, mem_addr_o=0.
  - Drop flag and timeout counter cleared.
  - Reset mid-transaction abandons it; a late rvalid arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - If ce_i, latch pc_i into addr_q.
  - pc_i[1:0]!=0: go directly to HOLD with inst_o=NOP_INST, err_o=1, no memory request.
  - Otherwise go to REQ.
- REQ:
  - mem_req_o=1 and mem_addr_o=addr_q, held stable until mem_gnt_i.
  - On mem_gnt_i: go to WAIT, counter=0.
  - redirect_i in REQ before grant: relatch pc_i and stay in REQ. This is the only permitted address change while req is high.
- WAIT:
  - Counter increments each cycle.
  - On mem_rvalid_i with drop=0: capture rdata into inst_o, inst_pc_o=addr_q, err_o=mem_err_i (if mem_err_i, inst_o=NOP_INST), then go to HOLD.
  - redirect_i in WAIT: set drop=1 and latch the new pc into addr_q.
  - On mem_rvalid_i with drop=1: discard the response, clear drop, go to REQ with the redirected address.
  - Counter reaches TIMEOUT without rvalid: go to HOLD with NOP_INST, err_o=1. A later stray rvalid is ignored.
- HOLD:
  - inst_valid_o=1; outputs held stable until consume_i.
  - On consume_i with ce_i: latch pc_i and go to REQ (or HOLD-with-error if misaligned) with no idle bubble.
  - On consume_i without ce_i: go to IDLE.
  - redirect_i in HOLD without consume_i: the held instruction is invalidated (inst_valid_o=0 next cycle), pc_i is latched, go to REQ.
  - redirect_i and consume_i in the same cycle: redirect wins, and the consume is a no-op on a dead instruction.
- busy_o=1 in REQ and WAIT.
- inst_valid_o is registered and asserts the cycle after entry to HOLD. Minimum fetch latency is 3 cycles from ce_i with zero-wait gnt/rvalid.
- At most one outstanding memory transaction at any time.

Optional Feature:
- Macro: IFU_FETCH_LASTHIT_EN.
- Defined:
  - Adds a one-entry tag/data register (last successful, non-error fetch address and instruction).
  - A fetch whose address equals the tag goes straight to HOLD with the cached instruction and issues no memory request.
  - The entry is cleared by rst and on any mem_err_i or timeout.
- Undefined: every fetch goes to memory; no extra registers.

Test Plan:
- Basic fetch: pc=0x80000000, gnt same cycle, rvalid 2 cycles later with 0x00100093 -> inst_o=0x00100093, inst_pc_o=0x80000000, inst_valid_o=1, err_o=0, exactly one mem_req_o grant.
- Back-to-back: consume_i with ce_i and pc=0x80000004 while in HOLD -> mem_req_o next cycle with addr 0x80000004, no IDLE cycle.
- Redirect during WAIT: redirect to 0x80000100, then old rvalid with 0xDEADBEEF -> data discarded, new request to 0x80000100, final inst_pc_o=0x80000100.
- Misaligned/error: pc=0x80000002 -> no mem_req_o, inst_o=0x00000013, err_o=1. Separately, rvalid with mem_err_i=1 -> NOP_INST, err_o=1.
- Timeout: grant, then no rvalid for 255 cycles -> HOLD with NOP, err_o=1; a stray rvalid afterwards changes nothing.
- Reset mid-WAIT: assert rst between clock edges -> all outputs 0 immediately; a later rvalid is ignored; next ce_i fetches normally.

Source files
------------

// File: rtl/ifu_fetch_ctrl_if.sv
// Instruction-memory port of the fetch controller: single-outstanding req/gnt request
// channel plus rvalid response channel.
interface ifu_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned INST_W = 32
);
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [INST_W-1:0] mem_rdata_i;
  logic              mem_err_i;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: latches the PC, issues one memory request at a time, handles
// redirects, misaligned PCs and timeouts. Define IFU_FETCH_LASTHIT_EN for a one-entry last-hit buffer.
module ifu_fetch_ctrl #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              redirect_i,
  input  logic              consume_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  output logic              err_o,
  output logic              busy_o,
  ifu_fetch_ctrl_if.master  mem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic              drop_q, drop_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              start;
  logic [ADDR_W-1:0] start_pc;
  logic              hit;

`ifdef IFU_FETCH_LASTHIT_EN
  logic [ADDR_W-1:0] lh_tag_q;
  logic [INST_W-1:0] lh_data_q;
  logic              lh_valid_q;

  assign hit = lh_valid_q && (lh_tag_q == start_pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lh_tag_q   <= '0;
      lh_data_q  <= '0;
      lh_valid_q <= 1'b0;
    end else if (state_q == S_WAIT && mem.mem_rvalid_i) begin
      if (mem.mem_err_i) begin
        lh_valid_q <= 1'b0;
      end else if (!drop_q && !redirect_i) begin
        lh_tag_q   <= addr_q;
        lh_data_q  <= mem.mem_rdata_i;
        lh_valid_q <= 1'b1;
      end
    end else if (state_q == S_WAIT && cnt_q == CNT_LAST) begin
      lh_valid_q <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // A new fetch starts from IDLE/HOLD, on a redirect, or after a dropped response
  always_comb begin
    start    = 1'b0;
    start_pc = pc_i;
    case (state_q)
      S_IDLE: start = ce_i;
      S_REQ:  start = redirect_i && !mem.mem_gnt_i;
      S_WAIT: begin
        if (mem.mem_rvalid_i && (redirect_i || drop_q)) begin
          start    = 1'b1;
          start_pc = redirect_i ? pc_i : addr_q;
        end
      end
      S_HOLD: start = redirect_i || (consume_i && ce_i);
      default: start = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    err_d   = err_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_REQ: begin
        // A redirect coinciding with grant: memory took the old address, so drop its response
        if (mem.mem_gnt_i) begin
          state_d = S_WAIT;
          cnt_d   = '0;
          if (redirect_i) begin
            addr_d = pc_i;
            drop_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem.mem_rvalid_i) begin
          if (!redirect_i && !drop_q) begin
            state_d = S_HOLD;
            valid_d = 1'b1;
            ipc_d   = addr_q;
            err_d   = mem.mem_err_i;
            inst_d  = mem.mem_err_i ? NOP_INST : mem.mem_rdata_i;
          end
        end else begin
          if (redirect_i) begin
            addr_d = pc_i;
            drop_d = 1'b1;
          end
          if (cnt_q == CNT_LAST) begin
            state_d = S_HOLD;
            valid_d = 1'b1;
            ipc_d   = addr_d;
            err_d   = 1'b1;
            inst_d  = NOP_INST;
            drop_d  = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (consume_i && !redirect_i && !ce_i) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (start) begin
      addr_d = start_pc;
      drop_d = 1'b0;
      if (start_pc[1:0] != 2'b00) begin
        state_d = S_HOLD;
        valid_d = 1'b1;
        ipc_d   = start_pc;
        err_d   = 1'b1;
        inst_d  = NOP_INST;
      end else if (hit) begin
        state_d = S_HOLD;
        valid_d = 1'b1;
        ipc_d   = start_pc;
        err_d   = 1'b0;
`ifdef IFU_FETCH_LASTHIT_EN
        inst_d  = lh_data_q;
`endif
      end else begin
        state_d = S_REQ;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      inst_q  <= '0;
      ipc_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  assign inst_o         = inst_q;
  assign inst_pc_o      = ipc_q;
  assign inst_valid_o   = valid_q;
  assign err_o          = err_q;
  assign busy_o         = (state_q == S_REQ) || (state_q == S_WAIT);
  assign mem.mem_req_o  = (state_q == S_REQ);
  assign mem.mem_addr_o = addr_q;

endmodule
